// File: rtl/risc8_mem_resp_pkg.sv
// risc8_defs: responder state encodings and address-region decode shared by the risc8 memory responder.
package risc8_defs;
  typedef enum logic [1:0] {RESP_IDLE, RESP_WAIT, RESP_ACK} resp_state_e;
  typedef enum logic [1:0] {REG_NONE, REG_MAIN, REG_STK} region_e;
  localparam logic [7:0] UNMAPPED_RD = 8'hFF;
  function automatic region_e decode(logic [15:0] a, int mem_depth, logic [15:0] stk_base, int stk_depth);
    int ai;
    ai = int'(a);
    return ai < mem_depth ? REG_MAIN :
           (ai >= int'(stk_base) && ai < int'(stk_base) + stk_depth) ? REG_STK : REG_NONE;
  endfunction
endpackage

// File: rtl/risc8_mem_resp_if.sv
// risc8_mem_resp_if: risc8 CPU bus between the CPU (master) and memory responder (slave).
interface risc8_mem_resp_if;
  logic cycle, write, ifetch, iack;
  logic [15:0] address;
  logic [7:0] data_out, int_vector, data_in;
  logic ready, int_ack, wr_err;
  modport master(output cycle, write, ifetch, iack, address, data_out, int_vector,
                 input data_in, ready, int_ack, wr_err);
  modport slave(input cycle, write, ifetch, iack, address, data_out, int_vector,
                output data_in, ready, int_ack, wr_err);
endinterface

// File: rtl/risc8_mem_resp_bank.sv
// risc8_mem_bank: byte array with clocked write and asynchronous read; contents survive reset.
module risc8_mem_bank #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/risc8_mem_resp.sv
// risc8_mem_resp: risc8 bus responder (main/stack RAM, iack vector, wait states); RISC8_MEM_PROG_WAIT_EN adds a wait-state reg at CFG_ADDR.
module risc8_mem_resp
  import risc8_defs::*;
#(
  parameter int          MEM_DEPTH   = 4096,
  parameter logic [15:0] ROM_TOP     = 16'h0400,
  parameter logic [15:0] STK_BASE    = 16'hEF00,
  parameter int          STK_DEPTH   = 256,
  parameter logic [3:0]  WAIT_STATES = 4'd1,
  parameter logic [15:0] CFG_ADDR    = 16'hFF00
) (
  input logic clk,
  input logic rst,
  risc8_mem_resp_if.slave bus
);
  localparam int MAW = $clog2(MEM_DEPTH);
  localparam int SAW = $clog2(STK_DEPTH);
  if (MEM_DEPTH > int'(STK_BASE)) begin : g_overlap
    $error("risc8_mem_resp: main array overlaps stack array");
  end
  resp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, w;
  logic [15:0] addr_q, addr_d, a;
  logic [7:0]  wdata_q, wdata_d, wd, data_in_q, data_in_d, rd, main_rd, stk_rd;
  logic        wr_q, wr_d, iack_q, iack_d, wr, ia;
  logic        ready_q, ready_d, int_ack_q, int_ack_d, wr_err_q, wr_err_d;
  logic        start, commit, acc, cfg, main_we, stk_we;
  logic [SAW-1:0] stk_idx;
  region_e     region;
`ifdef RISC8_MEM_PROG_WAIT_EN
  logic [3:0] w_q, w_d;
  assign w = w_q;
`else
  assign w = WAIT_STATES;
`endif
  always_comb begin
    // In IDLE the live bus is used so a zero-wait access commits on its capture edge
    a       = state_q == RESP_IDLE ? bus.address  : addr_q;
    wd      = state_q == RESP_IDLE ? bus.data_out : wdata_q;
    wr      = state_q == RESP_IDLE ? bus.write    : wr_q;
    ia      = state_q == RESP_IDLE ? bus.iack     : iack_q;
    start   = state_q == RESP_IDLE && bus.cycle;
    commit  = !rst && ((start && w == 4'd0) || (state_q == RESP_WAIT && bus.cycle && cnt_q == 4'd1));
`ifdef RISC8_MEM_PROG_WAIT_EN
    cfg     = a == CFG_ADDR;
    w_d     = commit && !ia && wr && cfg ? wd[3:0] : w_q;
`else
    cfg     = 1'b0;
`endif
    region  = decode(a, MEM_DEPTH, STK_BASE, STK_DEPTH);
    stk_idx = SAW'(a - STK_BASE);
    acc     = commit && !ia && wr && !cfg;
    main_we = acc && region == REG_MAIN && a >= ROM_TOP;
    stk_we  = acc && region == REG_STK;
    rd      = ia ? bus.int_vector : wr ? 8'h00 : cfg ? {4'h0, w} :
              region == REG_MAIN ? main_rd : region == REG_STK ? stk_rd : UNMAPPED_RD;
    state_d = state_q == RESP_ACK ? RESP_IDLE :
              start ? (w == 4'd0 ? RESP_ACK : RESP_WAIT) :
              state_q == RESP_WAIT ? (!bus.cycle ? RESP_IDLE : cnt_q == 4'd1 ? RESP_ACK : RESP_WAIT) :
              RESP_IDLE;
    cnt_d     = start ? w : state_q == RESP_WAIT ? cnt_q - 4'd1 : cnt_q;
    addr_d    = start ? bus.address  : addr_q;
    wdata_d   = start ? bus.data_out : wdata_q;
    wr_d      = start ? bus.write    : wr_q;
    iack_d    = start ? bus.iack     : iack_q;
    ready_d   = commit;
    int_ack_d = commit && ia;
    wr_err_d  = acc && !main_we && !stk_we;
    data_in_d = commit ? rd : data_in_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESP_IDLE;
      cnt_q     <= 4'd0;
      ready_q   <= 1'b0;
      data_in_q <= 8'h00;
      int_ack_q <= 1'b0;
      wr_err_q  <= 1'b0;
`ifdef RISC8_MEM_PROG_WAIT_EN
      w_q       <= WAIT_STATES;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      data_in_q <= data_in_d;
      int_ack_q <= int_ack_d;
      wr_err_q  <= wr_err_d;
`ifdef RISC8_MEM_PROG_WAIT_EN
      w_q       <= w_d;
`endif
    end
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
    iack_q  <= iack_d;
  end
  risc8_mem_bank #(.DEPTH(MEM_DEPTH)) u_main (
    .clk(clk), .we(main_we), .waddr(a[MAW-1:0]), .wdata(wd), .raddr(a[MAW-1:0]), .rdata(main_rd)
  );
  risc8_mem_bank #(.DEPTH(STK_DEPTH)) u_stk (
    .clk(clk), .we(stk_we), .waddr(stk_idx), .wdata(wd), .raddr(stk_idx), .rdata(stk_rd)
  );
  assign bus.ready   = ready_q;
  assign bus.data_in = data_in_q;
  assign bus.int_ack = int_ack_q;
  assign bus.wr_err  = wr_err_q;
endmodule

// File: tb/tb_risc8_mem_resp.sv
// tb_risc8_mem_resp: scoreboard bench for risc8_mem_resp (RISC8_MEM_PROG_WAIT_EN optional).
module tb_risc8_mem_resp;
  typedef struct {string tag; logic [7:0] data; logic ack; logic err;} exp_t;
  logic clk = 1'b0;
  logic rst;
  risc8_mem_resp_if bus();
  risc8_mem_resp dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  exp_t sb[$];
  exp_t got_e;
  logic [7:0] mdl [int];
  int n_cmp = 0, n_bad = 0;
  int w_mdl = 1;
  bit b2b = 1'b0, mon_en = 1'b0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit is_cfg(logic [15:0] a);
`ifdef RISC8_MEM_PROG_WAIT_EN
    return a == 16'hFF00;
`else
    return 1'b0;
`endif
  endfunction
  function automatic bit mapped(logic [15:0] a);
    return a < 16'h1000 || (a >= 16'hEF00 && a < 16'hF000);
  endfunction
  function automatic bit writable(logic [15:0] a);
    return (a >= 16'h0400 && a < 16'h1000) || (a >= 16'hEF00 && a < 16'hF000);
  endfunction
  function automatic logic [7:0] exp_rd(logic [15:0] a);
    if (is_cfg(a)) return {4'h0, 4'(w_mdl)};
    if (mapped(a) && mdl.exists(int'(a))) return mdl[int'(a)];
    return 8'hFF;
  endfunction
  task automatic poke(logic [15:0] a, logic [7:0] d);
    mdl[int'(a)] = d;
    if (a < 16'h1000) dut.u_main.mem[a[11:0]] = d;
    else dut.u_stk.mem[a[7:0]] = d;
  endtask
  task automatic xfer(string tag, bit ia, bit wr, bit ifc, logic [15:0] a, logic [7:0] d, bit keep);
    exp_t e;
    int n = 0;
    int lat = w_mdl + 1 + (b2b ? 1 : 0);
    e.tag  = tag;
    e.ack  = ia;
    e.data = ia ? d : wr ? 8'h00 : exp_rd(a);
    e.err  = !ia && wr && !is_cfg(a) && !writable(a);
    sb.push_back(e);
    bus.cycle = 1'b1; bus.write = wr; bus.iack = ia; bus.ifetch = ifc; bus.address = a;
    bus.data_out = ia ? 8'h99 : d;
    bus.int_vector = ia ? d : 8'h00;
    do begin @(posedge clk); #1; n++; end while (bus.ready !== 1'b1 && n < 40);
    check({tag, ".lat"}, n, lat);
    if (!ia && wr) begin
      if (is_cfg(a)) w_mdl = int'(d[3:0]);
      else if (writable(a)) mdl[int'(a)] = d;
    end
    b2b = keep;
    if (!keep) begin
      bus.cycle = 1'b0; bus.write = 1'b0; bus.iack = 1'b0; bus.ifetch = 1'b0;
      @(posedge clk); #1;
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (bus.ready === 1'b1) begin
        if (sb.size() == 0) check("unexpected_ready", 1, 0);
        else begin
          got_e = sb.pop_front();
          check({got_e.tag, ".data"}, bus.data_in, got_e.data);
          check({got_e.tag, ".int_ack"}, bus.int_ack, got_e.ack);
          check({got_e.tag, ".wr_err"}, bus.wr_err, got_e.err);
        end
      end else if (bus.int_ack !== 1'b0 || bus.wr_err !== 1'b0)
        check("stray_pulse", {bus.int_ack, bus.wr_err}, 0);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    bus.cycle = 1'b0; bus.write = 1'b0; bus.iack = 1'b0; bus.ifetch = 1'b0;
    bus.address = 16'h0; bus.data_out = 8'h0; bus.int_vector = 8'h0;
    #1;
    poke(16'h0010, 8'h5A); poke(16'h0100, 8'h42); poke(16'h0600, 8'h66); poke(16'h0500, 8'h55);
    for (int i = 0; i < 4; i++) poke(16'(i), 8'hA0 + 8'(i));
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", bus.ready, 0);
    check("rst.data_in", bus.data_in, 0);
    check("rst.int_ack", bus.int_ack, 0);
    check("rst.wr_err", bus.wr_err, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    xfer("rd0010", 0, 0, 0, 16'h0010, 8'h00, 0);
    check("ready_one_cycle", bus.ready, 0);
    xfer("wrEFF0", 0, 1, 0, 16'hEFF0, 8'hC3, 0);
    xfer("rdEFF0", 0, 0, 0, 16'hEFF0, 8'h00, 0);
    xfer("wr0100", 0, 1, 0, 16'h0100, 8'h11, 0);
    xfer("rd0100", 0, 0, 0, 16'h0100, 8'h00, 0);
    xfer("iack", 1, 1, 0, 16'h0600, 8'h07, 0);
    xfer("rd0600", 0, 0, 0, 16'h0600, 8'h00, 0);
    xfer("rd8000", 0, 0, 0, 16'h8000, 8'h00, 0);
    xfer("wr8000", 0, 1, 0, 16'h8000, 8'h12, 0);
    xfer("rd1000", 0, 0, 0, 16'h1000, 8'h00, 0);
    xfer("wr0FFF", 0, 1, 0, 16'h0FFF, 8'h5C, 0);
    xfer("rd0FFF", 0, 0, 0, 16'h0FFF, 8'h00, 0);
    xfer("wr0400", 0, 1, 0, 16'h0400, 8'h4D, 0);
    xfer("rd0400", 0, 0, 0, 16'h0400, 8'h00, 0);
    xfer("wrEF00", 0, 1, 0, 16'hEF00, 8'h3C, 0);
    xfer("rdEF00", 0, 0, 0, 16'hEF00, 8'h00, 0);
    xfer("rdF000", 0, 0, 0, 16'hF000, 8'h00, 0);
    xfer("rdEEFF", 0, 0, 0, 16'hEEFF, 8'h00, 0);
    bus.cycle = 1'b1; bus.write = 1'b1; bus.address = 16'h0500; bus.data_out = 8'h77;
    @(posedge clk); #1;
    bus.cycle = 1'b0;
    repeat (2) begin @(posedge clk); #1; check("abort.ready", bus.ready, 0); end
    bus.write = 1'b0;
    xfer("rd0500_abort", 0, 0, 0, 16'h0500, 8'h00, 0);
    bus.cycle = 1'b1; bus.write = 1'b1; bus.address = 16'h0500; bus.data_out = 8'h88;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstwait.ready", bus.ready, 0);
    check("rstwait.data_in", bus.data_in, 0);
    rst = 1'b0; bus.cycle = 1'b0; bus.write = 1'b0;
    xfer("rd0500_rst", 0, 0, 0, 16'h0500, 8'h00, 0);
    xfer("wrFF00", 0, 1, 0, 16'hFF00, 8'h03, 0);
    xfer("rd0010_w", 0, 0, 0, 16'h0010, 8'h00, 0);
    xfer("rdFF00", 0, 0, 0, 16'hFF00, 8'h00, 0);
    xfer("wrFF00_0", 0, 1, 0, 16'hFF00, 8'h00, 0);
    for (int i = 0; i < 4; i++) xfer($sformatf("ifetch%0d", i), 0, 0, 1, 16'(i), 8'h00, i < 3);
    xfer("rd8000_end", 0, 0, 0, 16'h8000, 8'h00, 0);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
